// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Width needed to hold a starve count from 0 up to max inclusive.
  function automatic int starve_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Winner selection for the arbiter: D has priority, IF wins after STARVE_MAX
// consecutive conflict losses.
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic enable,
  output logic win_if,
  output logic win_d
);

  localparam int SW = starve_w(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_r;
  logic          starved_s;
  logic          conflict_s;

  // Winner decode, qualified by enable (arbiter in IDLE).
  always_comb begin
    starved_s  = (starve_r == STARVE_LIM);
    conflict_s = if_req & d_req;
    win_d      = enable & d_req & ~(if_req & starved_s);
    win_if     = enable & if_req & (~d_req | starved_s);
  end

  // Starve counter: count D wins over a waiting IF, clear on any IF win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_r <= '0;
    end else if (win_if) begin
      starve_r <= '0;
    end else if (win_d && conflict_s && !starved_s) begin
      starve_r <= starve_r + SW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (D).
// Define MEM_ARB_STATS_EN to add grant/conflict statistics counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_if_cnt,
  output logic [31:0]         stat_d_cnt,
  output logic [31:0]         stat_conflict_cnt
`endif
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state_r, state_s;
  owner_t     owner_r;
  logic       win_if_s, win_d_s;

  logic              m_req_r, m_we_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic [BE_W-1:0]   m_be_r;
  logic              if_rvalid_r, d_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r, d_rdata_r;

  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .enable (state_r == IDLE),
    .win_if (win_if_s),
    .win_d  (win_d_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (win_if_s || win_d_s) state_s = REQ;  else state_s = IDLE;
      REQ:     if (m_gnt)               state_s = WAIT; else state_s = REQ;
      WAIT:    if (m_rvalid)            state_s = IDLE; else state_s = WAIT;
      default: state_s = IDLE;
    endcase
  end

  // Request capture, memory-side hold and response routing to the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r     <= OWN_IF;
      m_req_r     <= 1'b0;
      m_we_r      <= 1'b0;
      m_addr_r    <= '0;
      m_wdata_r   <= '0;
      m_be_r      <= '0;
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= '0;
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= '0;
    end else begin
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= '0;
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= '0;
      case (state_r)
        IDLE: begin
          if (win_if_s) begin
            owner_r   <= OWN_IF;
            m_req_r   <= 1'b1;
            m_we_r    <= 1'b0;
            m_addr_r  <= if_addr;
            m_wdata_r <= '0;
            m_be_r    <= '1;
          end else if (win_d_s) begin
            owner_r   <= OWN_D;
            m_req_r   <= 1'b1;
            m_we_r    <= d_we;
            m_addr_r  <= d_addr;
            m_wdata_r <= d_wdata;
            m_be_r    <= d_be;
          end
        end
        REQ: begin
          if (m_gnt) m_req_r <= 1'b0;
        end
        WAIT: begin
          if (m_rvalid) begin
            if (owner_r == OWN_IF) begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= m_rdata;
            end else begin
              d_rvalid_r <= 1'b1;
              // Stores return an acknowledge only; never leak bus data.
              d_rdata_r  <= m_we_r ? '0 : m_rdata;
            end
          end
        end
        default: m_req_r <= 1'b0;
      endcase
    end
  end

  assign if_gnt    = win_if_s;
  assign d_gnt     = win_d_s;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;
  assign m_req     = m_req_r;
  assign m_we      = m_we_r;
  assign m_addr    = m_addr_r;
  assign m_wdata   = m_wdata_r;
  assign m_be      = m_be_r;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_r, stat_d_r, stat_conflict_r;

  // Free-running, wrapping grant and conflict counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_if_r       <= 32'd0;
      stat_d_r        <= 32'd0;
      stat_conflict_r <= 32'd0;
    end else begin
      if (win_if_s) stat_if_r <= stat_if_r + 32'd1;
      if (win_d_s)  stat_d_r  <= stat_d_r + 32'd1;
      if (state_r == IDLE && if_req && d_req) stat_conflict_r <= stat_conflict_r + 32'd1;
    end
  end

  assign stat_if_cnt       = stat_if_r;
  assign stat_d_cnt        = stat_d_r;
  assign stat_conflict_cnt = stat_conflict_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (defaults: 32/32, STARVE_MAX=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_cnt, stat_d_cnt, stat_conflict_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_cnt(stat_if_cnt), .stat_d_cnt(stat_d_cnt),
    .stat_conflict_cnt(stat_conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_if;
    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    #12;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_be", m_be, 4'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_rvalid", {if_rvalid, d_rvalid, if_gnt, d_gnt}, 4'h0);
    tick();
    reset = 1'b1;

    // Single fetch, minimum latency.
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("fetch_if_gnt", if_gnt, 1'b1);
    chk("fetch_d_gnt", d_gnt, 1'b0);
    tick();
    if_req = 1'b0; if_addr = 32'h0;
    chk("fetch_m_req", m_req, 1'b1);
    chk("fetch_m_addr", m_addr, 32'h100);
    chk("fetch_m_be", m_be, 4'hF);
    chk("fetch_m_we", m_we, 1'b0);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    chk("fetch_m_req_drop", m_req, 1'b0);
    m_rvalid = 1'b1; m_rdata = 32'h00A00093;
    tick();
    m_rvalid = 1'b0;
    chk("fetch_if_rvalid", if_rvalid, 1'b1);
    chk("fetch_if_rdata", if_rdata, 32'h00A00093);
    chk("fetch_d_rvalid", d_rvalid, 1'b0);
    tick();
    chk("fetch_rvalid_pulse", if_rvalid, 1'b0);

    // Store with a 3-cycle memory grant delay.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    #1;
    chk("store_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    chk("store_m_addr", m_addr, 32'h2000);
    chk("store_m_wdata", m_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("store_hold", {m_req, m_we, m_be}, 6'b11_0011);
      tick();
    end
    chk("store_hold_last", {m_req, m_we, m_be}, 6'b11_0011);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h12345678;
    tick();
    m_rvalid = 1'b0;
    chk("store_d_rvalid", d_rvalid, 1'b1);
    chk("store_d_rdata", d_rdata, 32'h0);
    chk("store_if_rvalid", if_rvalid, 1'b0);

    // Continuous conflict: D,D,D,D,IF,D,D,D,D,IF.
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; d_be = 4'hF;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_if = (i == 4 || i == 9);
      chk($sformatf("conf_gnt_%0d", i), {if_gnt, d_gnt}, {exp_if, ~exp_if});
      tick();
      if (i == 9) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      chk($sformatf("conf_addr_%0d", i), m_addr, exp_if ? 32'h1000 : 32'h2004);
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hA0 + i;
      tick();
      m_rvalid = 1'b0;
      chk($sformatf("conf_rv_%0d", i), {if_rvalid, d_rvalid}, {exp_if, ~exp_if});
    end
`ifdef MEM_ARB_STATS_EN
    chk("stat_if", stat_if_cnt, 32'd3);
    chk("stat_d", stat_d_cnt, 32'd9);
    chk("stat_conflict", stat_conflict_cnt, 32'd10);
`endif

    // Memory stall in REQ: fields stable, waiting IF gets no grant.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    #1;
    chk("stall_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; d_addr = 32'h0;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {m_req, m_addr}, {1'b1, 32'h300});
      chk("stall_no_gnt", {if_gnt, d_gnt}, 2'b00);
      tick();
    end
    m_gnt = 1'b1;
    #1;
    chk("stall_gnt_cycle", if_gnt, 1'b0);
    tick();
    m_gnt = 1'b0;
    chk("stall_wait_no_gnt", if_gnt, 1'b0);
    m_rvalid = 1'b1; m_rdata = 32'h0000CAFE;
    tick();
    m_rvalid = 1'b0;
    chk("stall_d_rdata", {d_rvalid, d_rdata}, {1'b1, 32'h0000CAFE});
    chk("stall_if_b2b_gnt", if_gnt, 1'b1);
    tick();
    if_req = 1'b0;
    chk("stall_if_addr", m_addr, 32'h400);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h0000BEEF;
    tick();
    m_rvalid = 1'b0;
    chk("stall_if_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h0000BEEF});

    // Reset during WAIT; late response must be dropped.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    #1;
    chk("rmid_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0;
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    reset = 1'b0;
    #1;
    chk("rmid_outputs", {m_req, m_we, m_addr, m_be}, 38'h0);
    tick();
    reset = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h00000BAD;
    tick();
    m_rvalid = 1'b0;
    chk("rmid_no_rvalid", {if_rvalid, d_rvalid, d_rdata}, 34'h0);
`ifdef MEM_ARB_STATS_EN
    chk("rmid_stats_clr", {stat_if_cnt, stat_d_cnt, stat_conflict_cnt}, 96'h0);
`endif
    if_req = 1'b1; if_addr = 32'h600;
    #1;
    chk("rmid_if_gnt", if_gnt, 1'b1);
    tick();
    if_req = 1'b0;
    chk("rmid_m_addr", {m_req, m_addr}, {1'b1, 32'h600});
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h00000013;
    tick();
    m_rvalid = 1'b0;
    chk("rmid_if_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h00000013});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits between the pipelined datapath and the memory.
- Fixed priority to D, with a starvation guard for IF.
- One outstanding transaction; request/grant/valid handshake on both sides.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive IF losses before IF is forced to win

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted (combinational, IDLE only)
if_rvalid  out  1  fetch data valid, 1-cycle pulse
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_gnt  out  1  data accepted (combinational, IDLE only)
d_rvalid  out  1  load data or store acknowledge, 1-cycle pulse
d_rdata  out  DATA_W  load data; 0 for stores
m_req  out  1  memory request
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  DATA_W/8  memory byte enables (all ones for fetch)
m_gnt  in  1  memory accepted request
m_rvalid  in  1  memory response (read data or write ack)
m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset, asynchronous:
  - State IDLE, owner = IF, starve counter 0.
  - All outputs 0; m_* fields 0.
- FSM: IDLE -> REQ -> WAIT -> IDLE.
- IDLE arbitration:
  - Only d_req: D wins.
  - Only if_req: IF wins.
  - Both: D wins, unless starve == STARVE_MAX, then IF wins.
  - The winner's gnt is asserted the same cycle.
  - Request fields and owner are registered; next state is REQ.
  - With neither requesting, stay in IDLE.
- REQ:
  - m_req = 1 with registered fields, stable until m_gnt.
  - On m_gnt: next state WAIT, m_req drops the next cycle.
- WAIT:
  - On m_rvalid, register the response to the owner. Owner rvalid pulses high one cycle later and rdata is valid.
  - d_rdata = 0 for stores. The non-owner rdata/rvalid stay 0.
  - Next state IDLE.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when both request and D wins.
  - Clears when IF wins.
  - Unchanged otherwise.
- Minimum latency: req at cycle 0 -> gnt cycle 0 -> m_req cycle 1 (m_gnt same cycle) -> m_rvalid cycle 2 -> rvalid cycle 3.
- Back-to-back: next arbitration in the cycle rvalid is driven, so throughput is one transaction per 3 cycles minimum.
- m_rvalid in IDLE or REQ is ignored (stale response, e.g. after reset mid-transaction). m_rvalid never precedes m_gnt by contract.
- Requester dropping req before gnt: no effect; arbitration is per-cycle.
- Reset asserted mid-transaction: immediate IDLE; any in-flight response is dropped and no rvalid is produced.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds outputs stat_if_cnt, stat_d_cnt and stat_conflict_cnt, each 32 bits.
  - Counts IF grants, D grants, and IDLE cycles with both requests.
  - Counters wrap at 2^32; reset clears them.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, REQ, WAIT}.
  - owner_t enum {OWN_IF, OWN_D}.
  - Default width constants.
- One sub-module, arb_prio_sel: starve counter plus winner select (inputs if_req, d_req, enable; outputs win_if, win_d).

Test Plan:
- Single fetch: if_req, if_addr=0x100, m_gnt at cycle 1, m_rvalid with m_rdata=0x00A00093 at cycle 2 -> if_gnt cycle 0, m_be=0xF, if_rvalid cycle 3 with if_rdata=0x00A00093, d_rvalid stays 0.
- Store: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0x3 -> m_we=1, m_be=0x3 held until m_gnt; after a 3-cycle m_gnt delay, d_rvalid pulses with d_rdata=0.
- Conflict: if_req and d_req held continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF; counter clears on each IF grant.
- Stall: m_gnt low for 5 cycles in REQ -> m_req and fields stable, no new gnt issued; if_req held meanwhile gets no grant.
- Reset mid-WAIT: reset low for 1 cycle while awaiting m_rvalid, then m_rvalid arrives -> all outputs 0, no rvalid, next request arbitrated normally.
- With MEM_ARB_STATS_EN: run the conflict scenario for 10 grants -> stat_d_cnt=8, stat_if_cnt=2, stat_conflict_cnt=10.
